// File: rtl/regfile_wb_queue.sv
// Writeback queue between execute/memory results and the register file write port.
// Optional macro WB_QUEUE_BYPASS_EN builds the youngest-match forwarding mux for a1/a2.
module regfile_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         drain_hold,
    output logic                         we3,
    output logic [ADDR_WIDTH-1:0]        a3,
    output logic [DATA_WIDTH-1:0]        wd3,
    input  logic [ADDR_WIDTH-1:0]        a1,
    input  logic [ADDR_WIDTH-1:0]        a2,
    output logic                         hz1,
    output logic                         hz2,
    output logic [DATA_WIDTH-1:0]        fwd1_data,
    output logic [DATA_WIDTH-1:0]        fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]      vld_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;

    logic push_ok;
    logic pop;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign count    = count_reg;

    // Register-0 writes complete the handshake but are dropped here.
    assign push_ok = in_valid && in_ready && (in_addr != '0);
    assign pop     = we3;

    assign we3 = !empty && !drain_hold;
    assign a3  = addr_mem[rd_ptr_reg];
    assign wd3 = data_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
            vld_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (pop) begin
                vld_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg          <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_ok) begin
                vld_reg[wr_ptr_reg]  <= 1'b1;
                addr_mem[wr_ptr_reg] <= in_addr;
                data_mem[wr_ptr_reg] <= in_data;
                wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // The head still counts as pending during its retire cycle.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match1[gi] = vld_reg[gi] && (addr_mem[gi] == a1) && (a1 != '0);
            assign match2[gi] = vld_reg[gi] && (addr_mem[gi] == a2) && (a2 != '0);
        end
    endgenerate

    assign hz1 = |match1;
    assign hz2 = |match2;

`ifdef WB_QUEUE_BYPASS_EN
    // Walk from oldest to youngest so the last match seen wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_reg + PTR_W'(k);
            if (match1[idx]) fwd1_data = data_mem[idx];
            if (match2[idx]) fwd2_data = data_mem[idx];
        end
    end
`else
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: stimulus queues expected retirements,
// a negedge monitor compares every we3 cycle against the queue head.
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_hold;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  a1, a2;
    logic        hz1, hz2;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  count;
    logic        full, empty;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .drain_hold(drain_hold),
        .we3(we3), .a3(a3), .wd3(wd3),
        .a1(a1), .a2(a2), .hz1(hz1), .hz2(hz2),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count), .full(full), .empty(empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Drives one beat for one cycle; returns whether the handshake completed.
    task automatic push(input logic [4:0] a, input logic [31:0] d, output logic acc);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        #1;
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc && a != 5'd0) exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: each cycle with we3 high at negedge retires exactly one entry.
    always @(negedge clk) begin
        if (rst_n && we3) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_retire a3=%0d wd3=0x%0h expected=none t=%0t", a3, wd3, $time);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("retire_a3", {27'd0, a3}, {27'd0, e.addr});
                check("retire_wd3", wd3, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    logic acc;
    logic [31:0] exp_fwd;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        drain_hold = 1'b0; a1 = '0; a2 = '0;
        #12;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_we3", {31'd0, we3}, 32'd0);
        check("rst_fwd1", fwd1_data, 32'd0);
        rst_n = 1'b1;
        step();

        // Single push, earliest retirement the following cycle.
        push(5'd5, 32'h11, acc);
        check("single_we3", {31'd0, we3}, 32'd1);
        check("single_a3", {27'd0, a3}, 32'd5);
        check("single_wd3", wd3, 32'h11);
        step();
        check("single_empty_after", {31'd0, empty}, 32'd1);

        // Fill while held, reject a fifth beat, then drain back-to-back.
        drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i), acc);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_in_ready", {31'd0, in_ready}, 32'd0);
        check("fill_count", {29'd0, count}, 32'd4);
        check("fill_we3_held", {31'd0, we3}, 32'd0);
        push(5'd9, 32'h99, acc);
        check("fifth_accepted", {31'd0, acc}, 32'd0);
        check("fifth_count", {29'd0, count}, 32'd4);
        drain_hold = 1'b0;
        #1;
        check("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_count", {29'd0, count}, 32'(3 - i));
        end

        // Two writes to r7: hazard holds until both have retired.
        drain_hold = 1'b1;
        push(5'd7, 32'hA, acc);
        push(5'd7, 32'hB, acc);
        a1 = 5'd7; a2 = 5'd8;
        #1;
`ifdef WB_QUEUE_BYPASS_EN
        exp_fwd = 32'hB;
`else
        exp_fwd = 32'h0;
`endif
        check("r7_hz1", {31'd0, hz1}, 32'd1);
        check("r8_hz2", {31'd0, hz2}, 32'd0);
        check("r7_fwd1", fwd1_data, exp_fwd);
        drain_hold = 1'b0;
        #1;
        check("r7_hz1_head_retiring", {31'd0, hz1}, 32'd1);
        step();
        check("r7_hz1_one_left", {31'd0, hz1}, 32'd1);
        check("r7_fwd1_one_left", fwd1_data, exp_fwd);
        step();
        check("r7_hz1_cleared", {31'd0, hz1}, 32'd0);
        check("r7_fwd1_cleared", fwd1_data, 32'd0);

        // Youngest-match selection on a wrapped queue.
        drain_hold = 1'b1;
        push(5'd3, 32'h33, acc);
        push(5'd7, 32'h77, acc);
        push(5'd3, 32'h3333, acc);
        a1 = 5'd3; a2 = 5'd7;
        #1;
        check("young_hz1", {31'd0, hz1}, 32'd1);
        check("young_hz2", {31'd0, hz2}, 32'd1);
`ifdef WB_QUEUE_BYPASS_EN
        check("young_fwd1", fwd1_data, 32'h3333);
        check("young_fwd2", fwd2_data, 32'h77);
`else
        check("young_fwd1", fwd1_data, 32'h0);
        check("young_fwd2", fwd2_data, 32'h0);
`endif
        drain_hold = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("young_empty", {31'd0, empty}, 32'd1);

        // Register 0 writes are accepted and discarded.
        a1 = 5'd0; a2 = 5'd0;
        push(5'd0, 32'hFF, acc);
        check("r0_accepted", {31'd0, acc}, 32'd1);
        check("r0_count", {29'd0, count}, 32'd0);
        check("r0_empty", {31'd0, empty}, 32'd1);
        check("r0_hz1", {31'd0, hz1}, 32'd0);
        step();

        // Steady push+pop stream across pointer wrap.
        drain_hold = 1'b1;
        push(5'd10, 32'h200, acc);
        push(5'd11, 32'h201, acc);
        drain_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(5'(12 + i), 32'h300 + 32'(i), acc);
            check("stream_count", {29'd0, count}, 32'd2);
        end
        for (int i = 0; i < 20 && !empty; i++) step();
        check("stream_drained", {31'd0, empty}, 32'd1);

        // Reset mid-stream discards queued entries immediately.
        drain_hold = 1'b1;
        push(5'd21, 32'h21, acc);
        push(5'd22, 32'h22, acc);
        push(5'd23, 32'h23, acc);
        a1 = 5'd22;
        #1;
        check("pre_rst_hz1", {31'd0, hz1}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_we3", {31'd0, we3}, 32'd0);
        check("mid_rst_hz1", {31'd0, hz1}, 32'd0);
        drain_hold = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
